fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, PC value loaded on reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, return-address stack entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 prog_addr  output  12  program memory address.
REQ-006 prog_data  input  24  program memory word, valid one clk after prog_addr is presented (synchronous ROM).
REQ-007 stall  input  1  downstream microinstruction stage not ready; holds the current IR.
REQ-008 z_flag  input  1  zero flag from datapath, sampled in ISSUE.
REQ-009 cy_flag  input  1  carry flag from datapath, sampled in ISSUE.
REQ-010 IR  output  24  instruction word to the microinstruction ROM stage.
REQ-011 ir_valid  output  1  IR holds a new instruction this cycle.
REQ-012 pc  output  12  address of the instruction currently in IR.
REQ-013 stk_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-014 FSM states SHALL be FETCH, WAIT, ISSUE; transitions FETCH->WAIT->ISSUE unconditionally, ISSUE->FETCH when stall=0, ISSUE->ISSUE when stall=1.
REQ-015 In FETCH prog_addr SHALL equal the PC; in WAIT, prog_addr SHALL be held; on WAIT->ISSUE, IR SHALL load prog_data.
REQ-016 ir_valid SHALL be 1 only in ISSUE; IR, pc, and ir_valid SHALL stay stable while stall=1.
REQ-017 Throughput SHALL be one instruction per 3 cycles with stall=0; the first ir_valid after reset release SHALL occur on the 3rd rising edge.
REQ-018 Control group SHALL be decoded when IR[23:19]=5'b10000, with op=IR[19:12] and target T=IR[11:0].
REQ-019 On leaving ISSUE, next PC SHALL be: op 0 (JMP) T; op 1 (JZE) T if z_flag=1; op 2 (JNE) T if z_flag=0; op 3 (JCY) T if cy_flag=1; otherwise PC+1.
REQ-020 op 5 (BSR) SHALL push PC+1 and set PC=T; op 4 (RET) SHALL pop into PC.
REQ-021 Ops 6-7 and all non-control groups SHALL advance PC+1.
REQ-022 Flags SHALL be sampled on the ISSUE->FETCH edge only.
REQ-023 PC+1 and pushed PC+1 SHALL wrap 12'hFFF->12'h000 modulo 4096.
REQ-024 BSR with stack full SHALL not push, SHALL set PC=PC+1, and SHALL set stk_err.
REQ-025 RET with stack empty SHALL set PC=PC+1 and SHALL set stk_err.
REQ-026 Branch, push, and pop decisions SHALL be taken exactly once per instruction, regardless of stall length.
REQ-027 stk_err SHALL clear only on reset.

Reset
REQ-028 While rst_n=0: state=FETCH, PC=RESET_PC, prog_addr=RESET_PC, IR=24'h000000, ir_valid=0, pc=RESET_PC, stack pointer=0 (empty), stk_err=0.
REQ-029 Reset asserted mid-instruction SHALL abort immediately; no push/pop/PC update from the aborted instruction SHALL survive.

Verification
REQ-030 Straight-line: ROM[0..2]=24'h400000 NOPs, stall=0 -> ir_valid pulses on cycles 3,6,9; pc=0,1,2.
REQ-031 Conditional: ROM[0]=24'h801010 (JZE 0x010) with z_flag=0 -> next pc=1; repeat with z_flag=1 -> next pc=0x010.
REQ-032 Subroutine: ROM[0]=24'h805020 (BSR 0x020), ROM[0x020]=24'h804000 (RET) -> pc sequence 0, 0x020, 1; stk_err=0.
REQ-033 Stack fault: 9 nested BSR with STACK_DEPTH=8 -> 9th falls through to PC+1 with stk_err=1; RET from empty stack after reset -> PC+1, stk_err=1.
REQ-034 Stall: stall=1 for 5 cycles during ISSUE of JMP 0x0FF -> IR/pc held, ir_valid high throughout, one jump taken to 0x0FF.
REQ-035 Wrap/reset: PC=0xFFF NOP -> next pc=0x000; rst_n low during WAIT -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: three-phase instruction fetch sequencer (FETCH -> WAIT -> ISSUE).
// It presents the PC to a synchronous program ROM, latches the returned word
// into IR, and holds it while the downstream stage stalls. When the
// instruction retires, the sequencer resolves jumps, conditional branches and
// subroutine call/return through a small return-address stack.
module fetch_seq #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] prog_addr,
  input  logic [23:0] prog_data,
  input  logic        stall,
  input  logic        z_flag,
  input  logic        cy_flag,
  output logic [23:0] IR,
  output logic        ir_valid,
  output logic [11:0] pc,
  output logic        stk_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // Control-group opcodes, taken from IR[19:12].
  localparam logic [7:0] OP_JMP = 8'd0;
  localparam logic [7:0] OP_JZE = 8'd1;
  localparam logic [7:0] OP_JNE = 8'd2;
  localparam logic [7:0] OP_JCY = 8'd3;
  localparam logic [7:0] OP_RET = 8'd4;
  localparam logic [7:0] OP_BSR = 8'd5;

  state_t            r_state;
  logic [11:0]       r_pc;       // fetch address; doubles as prog_addr
  logic [23:0]       r_ir;
  logic [11:0]       r_ir_pc;    // address of the word now held in IR
  logic              r_valid;
  logic [SP_W-1:0]   r_sp;       // number of occupied stack entries
  logic              r_err;
  logic [11:0]       r_stack [STACK_DEPTH];

  logic              w_is_ctl;
  logic [7:0]        w_op;
  logic [11:0]       w_target;
  logic [11:0]       w_pc_inc;
  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_top_idx;
  logic              w_leave;
  logic [11:0]       w_next_pc;
  logic              w_push;
  logic              w_pop;
  logic              w_err_set;

  assign w_is_ctl   = (r_ir[23:19] == 5'b10000);
  assign w_op       = r_ir[19:12];
  assign w_target   = r_ir[11:0];
  // r_pc is unchanged between fetch and retirement, so it is the PC of IR here;
  // the 12-bit add wraps 12'hFFF to 12'h000 naturally.
  assign w_pc_inc   = r_pc + 12'd1;
  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
  // All branch/stack side effects happen on this single edge per instruction,
  // so a stall of any length cannot repeat them.
  assign w_leave    = (r_state == ISSUE) && !stall;

  // Resolve the successor PC and any stack action for the instruction in IR.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next_pc = w_pc_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (w_is_ctl) begin
      case (w_op)
        OP_JMP: w_next_pc = w_target;
        OP_JZE: if (z_flag)  w_next_pc = w_target;
        OP_JNE: if (!z_flag) w_next_pc = w_target;
        OP_JCY: if (cy_flag) w_next_pc = w_target;
        OP_RET: begin
          if (w_empty) begin
            w_err_set = 1'b1;
          end else begin
            w_pop     = 1'b1;
            w_next_pc = r_stack[w_top_idx];
          end
        end
        OP_BSR: begin
          if (w_full) begin
            w_err_set = 1'b1;
          end else begin
            w_push    = 1'b1;
            w_next_pc = w_target;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM with all architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 24'h000000;
      r_ir_pc <= RESET_PC;
      r_valid <= 1'b0;
      r_sp    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        FETCH: r_state <= WAIT;
        WAIT: begin
          r_state <= ISSUE;
          r_ir    <= prog_data;
          r_ir_pc <= r_pc;
          r_valid <= 1'b1;
        end
        ISSUE: begin
          if (!stall) begin
            r_state <= FETCH;
            r_valid <= 1'b0;
            r_pc    <= w_next_pc;
            if (w_push)     r_sp <= r_sp + SP_W'(1);
            else if (w_pop) r_sp <= r_sp - SP_W'(1);
            if (w_err_set)  r_err <= 1'b1;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Return-address storage; written only when a BSR retires with room.
  always_ff @(posedge clk) begin
    // NOTE: the stack array is deliberately not reset; r_sp=0 marks every
    // entry invalid, so clearing the storage would only cost reset fan-out.
    if (w_leave && w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign prog_addr = r_pc;
  assign IR        = r_ir;
  assign ir_valid  = r_valid;
  assign pc        = r_ir_pc;
  assign stk_err   = r_err;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed stimulus for fetch_seq against an architectural model
// (PC, return-stack queue, sticky error, fetch latency), compared on every
// falling edge; directed tests additionally pin literal pc sequences.
module tb_fetch_seq;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [11:0] prog_addr;
  logic [23:0] prog_data;
  logic        stall;
  logic        z_flag;
  logic        cy_flag;
  logic [23:0] IR;
  logic        ir_valid;
  logic [11:0] pc;
  logic        stk_err;

  fetch_seq #(.RESET_PC(12'h000), .STACK_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .stall    (stall),
    .z_flag   (z_flag),
    .cy_flag  (cy_flag),
    .IR       (IR),
    .ir_valid (ir_valid),
    .pc       (pc),
    .stk_err  (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM: data appears one clock after the address.
  logic [23:0] rom [4096];
  always @(posedge clk) prog_data <= rom[prog_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [11:0] m_pc;
  logic [11:0] m_ir_pc;
  logic [23:0] m_ir;
  logic        m_valid;
  logic        m_err;
  int          m_cnt;
  int          m_edges;
  logic [11:0] m_stack [$];
  logic [11:0] m_inc;
  logic [11:0] m_nxt;
  logic        prev_v;
  logic [11:0] pc_log [$];
  int          edge_log [$];

  // Inputs change only just after a rising edge, so on the falling edge the
  // model sees exactly what the DUT will sample on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst prog_addr", prog_addr, 12'h000);
      check("rst IR", IR, 24'h000000);
      check("rst ir_valid", ir_valid, 1'b0);
      check("rst pc", pc, 12'h000);
      check("rst stk_err", stk_err, 1'b0);
      m_pc = 12'h000; m_ir_pc = 12'h000; m_ir = 24'h0; m_valid = 1'b0;
      m_err = 1'b0; m_cnt = 0; m_edges = 0; prev_v = 1'b0;
      m_stack.delete(); pc_log.delete(); edge_log.delete();
    end else begin
      check("ir_valid", ir_valid, m_valid);
      check("pc", pc, m_ir_pc);
      check("IR", IR, m_ir);
      check("stk_err", stk_err, m_err);
      if (!m_valid) check("prog_addr", prog_addr, m_pc);
      if (ir_valid && !prev_v) begin
        pc_log.push_back(pc);
        edge_log.push_back(m_edges + 1);
      end
      prev_v = ir_valid;
      // Predict the effect of the coming rising edge.
      if (m_valid) begin
        if (!stall) begin
          m_inc = m_ir_pc + 12'd1;
          m_nxt = m_inc;
          if (m_ir[23:19] == 5'b10000) begin
            case (m_ir[19:12])
              8'd0: m_nxt = m_ir[11:0];
              8'd1: if (z_flag)  m_nxt = m_ir[11:0];
              8'd2: if (!z_flag) m_nxt = m_ir[11:0];
              8'd3: if (cy_flag) m_nxt = m_ir[11:0];
              8'd4: if (m_stack.size() == 0) m_err = 1'b1;
                    else m_nxt = m_stack.pop_back();
              8'd5: if (m_stack.size() == DEPTH) m_err = 1'b1;
                    else begin m_stack.push_back(m_inc); m_nxt = m_ir[11:0]; end
              default: ;
            endcase
          end
          m_pc = m_nxt;
          m_valid = 1'b0;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 2) begin
          m_valid = 1'b1;
          m_ir = rom[m_pc];
          m_ir_pc = m_pc;
        end
      end
      m_edges++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_nops();
    for (int i = 0; i < 4096; i++) rom[i] = 24'h400000;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic lvl);
    int k;
    k = 0;
    while (ir_valid !== lvl && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 20) check("wait ir_valid timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [11:0] log_at(input int i);
    if (i < pc_log.size()) return pc_log[i];
    return 12'hBAD;
  endfunction

  initial begin
    rst_n = 1'b0; stall = 1'b0; z_flag = 1'b0; cy_flag = 1'b0;
    fill_nops();

    // Straight-line NOPs: sampled valid at edges 3,6,9 with pc 0,1,2.
    do_reset();
    run(10);
    check("nop edge0", (edge_log.size() > 0) ? edge_log[0] : -1, 3);
    check("nop edge1", (edge_log.size() > 1) ? edge_log[1] : -1, 6);
    check("nop edge2", (edge_log.size() > 2) ? edge_log[2] : -1, 9);
    check("nop pc0", log_at(0), 12'h000);
    check("nop pc1", log_at(1), 12'h001);
    check("nop pc2", log_at(2), 12'h002);

    // JZE 0x010 not taken, then taken.
    rom[0] = 24'h801010;
    z_flag = 1'b0;
    do_reset(); run(9);
    check("jze z0 next", log_at(1), 12'h001);
    z_flag = 1'b1;
    do_reset(); run(9);
    check("jze z1 next", log_at(1), 12'h010);
    z_flag = 1'b0;

    // JNE / JCY with the opposite sense.
    rom[0] = 24'h802030;
    do_reset(); run(9);
    check("jne z0 next", log_at(1), 12'h030);
    rom[0] = 24'h803040;
    cy_flag = 1'b1;
    do_reset(); run(9);
    check("jcy cy1 next", log_at(1), 12'h040);
    cy_flag = 1'b0;

    // BSR 0x020 / RET.
    rom[0]     = 24'h805020;
    rom[12'h020] = 24'h804000;
    do_reset(); run(12);
    check("bsr pc0", log_at(0), 12'h000);
    check("bsr pc1", log_at(1), 12'h020);
    check("ret pc2", log_at(2), 12'h001);
    check("bsr stk_err", stk_err, 1'b0);

    // Nine nested BSRs; the ninth finds the stack full.
    fill_nops();
    rom[0] = 24'h805010;
    for (int k = 1; k <= 8; k++) rom[k * 16] = 24'h805000 | 24'((k + 1) * 16);
    do_reset(); run(32);
    check("nest 8th", log_at(8), 12'h080);
    check("nest 9th fallthru", log_at(9), 12'h081);
    check("nest stk_err", stk_err, 1'b1);

    // Reset while a BSR is stalled in ISSUE: no push survives, so a RET
    // afterwards underflows and falls through.
    fill_nops();
    rom[0] = 24'h805020;
    do_reset();
    wait_level(1'b1);
    stall = 1'b1;
    run(1);
    rst_n = 1'b0; stall = 1'b0;
    rom[0] = 24'h804000;
    run(2);
    rst_n = 1'b1;
    run(9);
    check("ret empty next", log_at(1), 12'h001);
    check("ret empty stk_err", stk_err, 1'b1);

    // JMP 0x0FF held by a 5-cycle stall.
    fill_nops();
    rom[0] = 24'h8000FF;
    do_reset();
    wait_level(1'b1);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run(1);
      check("stall ir_valid", ir_valid, 1'b1);
      check("stall pc", pc, 12'h000);
      check("stall IR", IR, 24'h8000FF);
    end
    stall = 1'b0;
    run(7);
    check("stall jmp pc1", log_at(1), 12'h0FF);
    check("stall jmp pc2", log_at(2), 12'h100);

    // PC wrap 0xFFF -> 0x000.
    rom[0] = 24'h800FFF;
    do_reset(); run(12);
    check("wrap pc1", log_at(1), 12'hFFF);
    check("wrap pc2", log_at(2), 12'h000);

    // Reset asserted during WAIT takes effect within the same cycle.
    wait_level(1'b1);
    wait_level(1'b0);
    run(1);
    rst_n = 1'b0;
    #1;
    check("async rst prog_addr", prog_addr, 12'h000);
    check("async rst IR", IR, 24'h000000);
    check("async rst ir_valid", ir_valid, 1'b0);
    check("async rst pc", pc, 12'h000);
    check("async rst stk_err", stk_err, 1'b0);
    run(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
